// File: rtl/icache_responder_pkg.sv
// -----------------------------------------------------------------------------
// icache_responder_pkg
// Shared definitions for the fetch-side instruction cache:
//   - FSM state encodings (ICACHE_IDLE, ICACHE_FILL)
//   - the processor reset vector (first fetch address after reset)
//   - helper functions deriving offset/index/tag widths from the geometry
// Optional feature macro used by the top module: ICACHE_PERF_EN.
// -----------------------------------------------------------------------------
package icache_responder_pkg;

    typedef enum logic [0:0] {
        ICACHE_IDLE = 1'b0,
        ICACHE_FILL = 1'b1
    } icache_state_e;

    localparam logic [31:0] ICACHE_RESET_VECTOR = 32'hBFC0_0000;

    // Byte-within-word address bits; instruction words are always aligned.
    localparam int unsigned ICACHE_BYTE_BITS = 2;

    // Word-offset width inside a line.
    function automatic int unsigned icache_off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Line-index width.
    function automatic int unsigned icache_idx_w(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag width: everything above byte, offset and index bits.
    function automatic int unsigned icache_tag_w(input int unsigned num_lines,
                                                 input int unsigned line_words);
        return 32 - ICACHE_BYTE_BITS - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage : icache_responder_pkg

// File: rtl/icache_data_array.sv
// -----------------------------------------------------------------------------
// icache_data_array
// Instruction word storage of NUM_LINES x LINE_WORDS 32-bit words.
// Ports:
//   CLK                      clock for the write port
//   write_en/index/offset    synchronous write of one fill word
//   write_data               word to store
//   read_index/read_offset   asynchronous (combinational) read address
//   read_data                word at the read address
// The storage carries no reset: a word is only ever delivered once its line's
// valid bit (held in the top module) has been set by a complete fill.
// -----------------------------------------------------------------------------
module icache_data_array
    import icache_responder_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                                CLK,
    input  logic                                write_en,
    input  logic [icache_idx_w(NUM_LINES)-1:0]  write_index,
    input  logic [icache_off_w(LINE_WORDS)-1:0] write_offset,
    input  logic [31:0]                         write_data,
    input  logic [icache_idx_w(NUM_LINES)-1:0]  read_index,
    input  logic [icache_off_w(LINE_WORDS)-1:0] read_offset,
    output logic [31:0]                         read_data
);

    localparam int unsigned DEPTH = NUM_LINES * LINE_WORDS;

    logic [31:0] mem_r [DEPTH];

    // Fill-beat write port.
    always_ff @(posedge CLK) begin
        if (write_en) begin
            mem_r[{write_index, write_offset}] <= write_data;
        end else begin
            mem_r[{write_index, write_offset}] <= mem_r[{write_index, write_offset}];
        end
    end

    // Combinational hit-path read.
    assign read_data = mem_r[{read_index, read_offset}];

endmodule : icache_data_array

// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
// Direct-mapped, read-only instruction cache between the fetch stage and main
// memory. Hits are answered combinationally; a miss stalls fetch and fills the
// whole line, one word per Mem_valid_fMEM beat, starting at the line base.
// Ports:
//   CLK, RESET          clock; synchronous active-low reset
//   Instr_address_fIF   fetch address (bits [1:0] ignored)
//   Instr1_2IF          instruction word (0 while not deliverable)
//   Stall_2IF           fetch stall
//   Flush               invalidate every line
//   Mem_address_2MEM    word-aligned fill beat address (registered)
//   Mem_req_2MEM        fill beat request (registered)
//   Mem_data_fMEM       fill data
//   Mem_valid_fMEM      fill beat completes
//   Hit_count, Miss_count  performance counters, present only when the
//                          ICACHE_PERF_EN macro is defined
// -----------------------------------------------------------------------------
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr_address_fIF,
    output logic [31:0] Instr1_2IF,
    output logic        Stall_2IF,
    input  logic        Flush,
    output logic [31:0] Mem_address_2MEM,
    output logic        Mem_req_2MEM,
    input  logic [31:0] Mem_data_fMEM,
    input  logic        Mem_valid_fMEM
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] Hit_count,
    output logic [31:0] Miss_count
`endif
);

    localparam int unsigned OFF_W = icache_off_w(LINE_WORDS);
    localparam int unsigned IDX_W = icache_idx_w(NUM_LINES);
    localparam int unsigned TAG_W = icache_tag_w(NUM_LINES, LINE_WORDS);
    localparam int unsigned OB    = ICACHE_BYTE_BITS + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    // Address fields of the current fetch.
    logic [OFF_W-1:0] addr_offset_s;
    logic [IDX_W-1:0] addr_index_s;
    logic [TAG_W-1:0] addr_tag_s;
    logic [31:0]      line_base_s;
    logic             addr_unused_s;

    assign addr_offset_s = Instr_address_fIF[OB-1:ICACHE_BYTE_BITS];
    assign addr_index_s  = Instr_address_fIF[OB +: IDX_W];
    assign addr_tag_s    = Instr_address_fIF[31 -: TAG_W];
    assign line_base_s   = {Instr_address_fIF[31:OB], {OB{1'b0}}};
    assign addr_unused_s = ^Instr_address_fIF[ICACHE_BYTE_BITS-1:0];

    // State.
    icache_state_e    state_r;
    icache_state_e    state_next_s;
    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_r [NUM_LINES];
    logic [IDX_W-1:0] line_index_r;
    logic [OFF_W-1:0] beat_cnt_r;
    logic             poison_r;
    logic             mem_req_r;
    logic [31:0]      mem_addr_r;

    // Decoded per-cycle controls.
    logic        hit_s;
    logic        miss_s;
    logic        fill_beat_s;
    logic        fill_done_s;
    logic        stall_s;
    logic [31:0] instr_s;
    logic [31:0] read_data_s;

    assign hit_s = valid_r[addr_index_s] && (tag_r[addr_index_s] == addr_tag_s);

    icache_data_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_data_array (
        .CLK          (CLK),
        .write_en     (fill_beat_s),
        .write_index  (line_index_r),
        .write_offset (beat_cnt_r),
        .write_data   (Mem_data_fMEM),
        .read_index   (addr_index_s),
        .read_offset  (addr_offset_s),
        .read_data    (read_data_s)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= ICACHE_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and hit-path outputs.
    always_comb begin
        state_next_s = state_r;
        stall_s      = 1'b1;
        instr_s      = 32'h0000_0000;
        miss_s       = 1'b0;
        fill_beat_s  = 1'b0;
        fill_done_s  = 1'b0;
        case (state_r)
            ICACHE_IDLE: begin
                if (hit_s) begin
                    stall_s = 1'b0;
                    instr_s = read_data_s;
                end else begin
                    miss_s       = 1'b1;
                    state_next_s = ICACHE_FILL;
                end
            end
            ICACHE_FILL: begin
                // Memory beats only count here; a stray valid in IDLE is ignored.
                if (Mem_valid_fMEM) begin
                    fill_beat_s = 1'b1;
                    if (beat_cnt_r == LAST_BEAT) begin
                        fill_done_s  = 1'b1;
                        state_next_s = ICACHE_IDLE;
                    end else begin
                        fill_done_s  = 1'b0;
                    end
                end else begin
                    fill_beat_s = 1'b0;
                end
            end
            default: begin
                state_next_s = ICACHE_IDLE;
            end
        endcase
    end

    // Valid bits, fill bookkeeping and the registered memory request.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid_r      <= '0;
            line_index_r <= '0;
            beat_cnt_r   <= '0;
            poison_r     <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ICACHE_IDLE: begin
                    poison_r <= 1'b0;
                    if (Flush) begin
                        valid_r <= '0;
                    end
                    if (miss_s) begin
                        // Tag is written now; valid stays low until the last beat.
                        valid_r[addr_index_s] <= 1'b0;
                        line_index_r          <= addr_index_s;
                        beat_cnt_r            <= '0;
                        mem_req_r             <= 1'b1;
                        mem_addr_r            <= line_base_s;
                    end
                end
                ICACHE_FILL: begin
                    // A flush racing a fill must not let the stale line go valid.
                    if (Flush) begin
                        poison_r <= 1'b1;
                    end
                    if (fill_beat_s) begin
                        beat_cnt_r <= beat_cnt_r + OFF_W'(1);
                        mem_addr_r <= mem_addr_r + 32'd4;
                        if (fill_done_s) begin
                            valid_r[line_index_r] <= !(poison_r || Flush);
                            poison_r              <= 1'b0;
                            mem_req_r             <= 1'b0;
                        end
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Tag array: written on every miss, read combinationally for the lookup.
    always_ff @(posedge CLK) begin
        if (miss_s && RESET) begin
            tag_r[addr_index_s] <= addr_tag_s;
        end else begin
            tag_r[addr_index_s] <= tag_r[addr_index_s];
        end
    end

    assign Instr1_2IF       = instr_s;
    assign Stall_2IF        = stall_s;
    assign Mem_req_2MEM     = mem_req_r;
    assign Mem_address_2MEM = mem_addr_r;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            if ((state_r == ICACHE_IDLE) && hit_s) begin
                hit_count_r <= hit_count_r + 32'd1;
            end
            if (miss_s) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign Hit_count  = hit_count_r;
    assign Miss_count = miss_count_r;
`endif

endmodule : icache_responder

// File: tb/tb_icache_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_responder
// Directed bench for icache_responder (64 lines x 4 words). Backing memory
// returns mdata(addr) for every word address; expected fill addresses and
// instruction words are computed here from the bench's own address constants.
// -----------------------------------------------------------------------------
module tb_icache_responder;
    import icache_responder_pkg::*;

    logic        CLK;
    logic        RESET;
    logic [31:0] Instr_address_fIF;
    logic [31:0] Instr1_2IF;
    logic        Stall_2IF;
    logic        Flush;
    logic [31:0] Mem_address_2MEM;
    logic        Mem_req_2MEM;
    logic [31:0] Mem_data_fMEM;
    logic        Mem_valid_fMEM;
`ifdef ICACHE_PERF_EN
    logic [31:0] Hit_count;
    logic [31:0] Miss_count;
`endif

    int checks;
    int failures;

    icache_responder #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Instr_address_fIF (Instr_address_fIF),
        .Instr1_2IF        (Instr1_2IF),
        .Stall_2IF         (Stall_2IF),
        .Flush             (Flush),
        .Mem_address_2MEM  (Mem_address_2MEM),
        .Mem_req_2MEM      (Mem_req_2MEM),
        .Mem_data_fMEM     (Mem_data_fMEM),
        .Mem_valid_fMEM    (Mem_valid_fMEM)
`ifdef ICACHE_PERF_EN
        ,
        .Hit_count         (Hit_count),
        .Miss_count        (Miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Content of backing memory at a word address.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a ^ 32'hA5C3_0F1E) + {a[15:0], a[31:16]};
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Current cycle must be an IDLE miss on the presented address; then
    // serves the whole fill, checking each cycle. Ends one cycle after the
    // last beat (back in IDLE). flush_beat < 0 means no flush.
    task automatic do_fill(input logic [31:0] base, input int waits,
                           input int flush_beat, input string name);
        @(negedge CLK);
        checks++;
        if (Stall_2IF !== 1'b1 || Instr1_2IF !== 32'h0 || Mem_req_2MEM !== 1'b0) begin
            failures++;
            $display("FAIL %s miss_cycle stall=%b instr=%h req=%b expected stall=1 instr=0 req=0",
                     name, Stall_2IF, Instr1_2IF, Mem_req_2MEM);
        end
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < waits; w++) begin
                Mem_valid_fMEM = 1'b0;
                @(negedge CLK);
                checks++;
                if (Mem_address_2MEM !== base + 32'(4 * b) || Mem_req_2MEM !== 1'b1 ||
                    Stall_2IF !== 1'b1) begin
                    failures++;
                    $display("FAIL %s wait_beat%0d addr=%h req=%b stall=%b expected addr=%h req=1 stall=1",
                             name, b, Mem_address_2MEM, Mem_req_2MEM, Stall_2IF, base + 32'(4 * b));
                end
                next_cycle();
            end
            Mem_valid_fMEM = 1'b1;
            Mem_data_fMEM  = mdata(base + 32'(4 * b));
            Flush          = (b == flush_beat);
            @(negedge CLK);
            checks++;
            if (Mem_address_2MEM !== base + 32'(4 * b) || Mem_req_2MEM !== 1'b1 ||
                Stall_2IF !== 1'b1 || Instr1_2IF !== 32'h0) begin
                failures++;
                $display("FAIL %s beat%0d addr=%h req=%b stall=%b instr=%h expected addr=%h req=1 stall=1 instr=0",
                         name, b, Mem_address_2MEM, Mem_req_2MEM, Stall_2IF, Instr1_2IF,
                         base + 32'(4 * b));
            end
            next_cycle();
            Mem_valid_fMEM = 1'b0;
            Flush          = 1'b0;
        end
    endtask

    // Present an address that must hit this cycle.
    task automatic check_hit(input logic [31:0] a, input string name);
        Instr_address_fIF = a;
        @(negedge CLK);
        checks++;
        if (Stall_2IF !== 1'b0 || Instr1_2IF !== mdata(a) || Mem_req_2MEM !== 1'b0) begin
            failures++;
            $display("FAIL %s hit_%h stall=%b instr=%h req=%b expected stall=0 instr=%h req=0",
                     name, a, Stall_2IF, Instr1_2IF, Mem_req_2MEM, mdata(a));
        end
        next_cycle();
    endtask

    task automatic test_reset();
        RESET             = 1'b0;
        Flush             = 1'b0;
        Mem_valid_fMEM    = 1'b0;
        Mem_data_fMEM     = 32'h0;
        Instr_address_fIF = ICACHE_RESET_VECTOR;
        repeat (3) next_cycle();
        @(negedge CLK);
        checks++;
        if (Stall_2IF !== 1'b1 || Instr1_2IF !== 32'h0 || Mem_req_2MEM !== 1'b0 ||
            Mem_address_2MEM !== 32'h0) begin
            failures++;
            $display("FAIL reset_state stall=%b instr=%h req=%b addr=%h expected 1 0 0 0",
                     Stall_2IF, Instr1_2IF, Mem_req_2MEM, Mem_address_2MEM);
        end
`ifdef ICACHE_PERF_EN
        checks++;
        if (Hit_count !== 32'd0 || Miss_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters hit=%0d miss=%0d expected 0 0", Hit_count, Miss_count);
        end
`endif
        next_cycle();
        RESET = 1'b1;
    endtask

    task automatic test_cold_start();
        Instr_address_fIF = ICACHE_RESET_VECTOR;
        do_fill(ICACHE_RESET_VECTOR, 0, -1, "cold");
        check_hit(ICACHE_RESET_VECTOR, "cold");
    endtask

    task automatic test_hit_sweep();
        for (int i = 1; i < 4; i++) begin
            check_hit(ICACHE_RESET_VECTOR + 32'(4 * i), "sweep");
        end
`ifdef ICACHE_PERF_EN
        @(negedge CLK);
        checks++;
        if (Hit_count !== 32'd4 || Miss_count !== 32'd1) begin
            failures++;
            $display("FAIL perf_counts hit=%0d miss=%0d expected 4 1", Hit_count, Miss_count);
        end
        next_cycle();
`endif
    endtask

    task automatic test_reset_mid_fill();
        Instr_address_fIF = 32'h0000_0040;
        @(negedge CLK);
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            Mem_valid_fMEM = 1'b1;
            Mem_data_fMEM  = mdata(32'h0000_0040 + 32'(4 * b));
            next_cycle();
        end
        // Beat 2 presented together with reset; it must be discarded.
        Mem_valid_fMEM = 1'b1;
        Mem_data_fMEM  = mdata(32'h0000_0048);
        RESET          = 1'b0;
        next_cycle();
        Mem_valid_fMEM = 1'b0;
        @(negedge CLK);
        checks++;
        if (Mem_req_2MEM !== 1'b0 || Mem_address_2MEM !== 32'h0 || Stall_2IF !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_fill req=%b addr=%h stall=%b expected req=0 addr=0 stall=1",
                     Mem_req_2MEM, Mem_address_2MEM, Stall_2IF);
        end
`ifdef ICACHE_PERF_EN
        checks++;
        if (Hit_count !== 32'd0 || Miss_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_fill_counters hit=%0d miss=%0d expected 0 0", Hit_count, Miss_count);
        end
`endif
        next_cycle();
        RESET = 1'b1;
        do_fill(32'h0000_0040, 0, -1, "refill_after_reset");
        check_hit(32'h0000_0048, "refill_after_reset");
        // The line filled before reset must be gone.
        Instr_address_fIF = ICACHE_RESET_VECTOR + 32'd8;
        do_fill(ICACHE_RESET_VECTOR, 0, -1, "reset_cleared_valid");
        check_hit(ICACHE_RESET_VECTOR + 32'd8, "reset_cleared_valid");
    endtask

    task automatic test_conflict();
        Instr_address_fIF = 32'hBFC0_1004;
        do_fill(32'hBFC0_1000, 0, -1, "conflict_new");
        check_hit(32'hBFC0_1004, "conflict_new");
        check_hit(32'hBFC0_100C, "conflict_new");
        Instr_address_fIF = ICACHE_RESET_VECTOR;
        do_fill(ICACHE_RESET_VECTOR, 0, -1, "conflict_old");
        check_hit(ICACHE_RESET_VECTOR, "conflict_old");
    endtask

    task automatic test_wait_states();
        Instr_address_fIF = 32'h2000_0088;
        // Valid every third cycle: 1 miss cycle + 4 beats x 3 cycles = 13 stalled cycles.
        do_fill(32'h2000_0080, 2, -1, "wait");
        check_hit(32'h2000_0088, "wait");
        check_hit(32'h2000_0080, "wait");
    endtask

    task automatic test_flush();
        Instr_address_fIF = 32'h0000_0104;
        do_fill(32'h0000_0100, 0, 1, "flush_fill");
        // Poisoned fill: same address misses and refills completely.
        do_fill(32'h0000_0100, 0, -1, "flush_refill");
        check_hit(32'h0000_0104, "flush_refill");
        // Flush in IDLE: this cycle still hits, the next one misses.
        Flush = 1'b1;
        @(negedge CLK);
        checks++;
        if (Stall_2IF !== 1'b0 || Instr1_2IF !== mdata(32'h0000_0104)) begin
            failures++;
            $display("FAIL flush_idle_same_cycle stall=%b instr=%h expected stall=0 instr=%h",
                     Stall_2IF, Instr1_2IF, mdata(32'h0000_0104));
        end
        next_cycle();
        Flush = 1'b0;
        do_fill(32'h0000_0100, 0, -1, "flush_idle_refill");
        check_hit(32'h0000_0104, "flush_idle_refill");
        // Stray memory valid in IDLE must not disturb anything.
        Mem_valid_fMEM = 1'b1;
        Mem_data_fMEM  = 32'hDEAD_BEEF;
        check_hit(32'h0000_0108, "idle_valid_ignored");
        Mem_valid_fMEM = 1'b0;
        check_hit(32'h0000_0108, "idle_valid_ignored");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_cold_start();
        test_hit_sweep();
        test_reset_mid_fill();
        test_conflict();
        test_wait_states();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded bound");
        $fatal(1, "timeout");
    end

endmodule : tb_icache_responder
